// File: rtl/bus_pkg.sv
// Shared types for the core command bus: instruction encoding and bus FSM states.
package bus_pkg;

  typedef enum logic [1:0] {
    HALT_PAUSE = 2'b00,
    STOP       = 2'b01,
    CONTINUE   = 2'b10,
    DONE       = 2'b11
  } bus_instruction_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } cmd_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr_i, wrapping.
module rr_arbiter #(
  parameter int  N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_cmd_bus.sv
// Shared command bus: latches per-source send requests, arbitrates round-robin,
// drives the winner to its target core(s) and holds it until all targets ack.
module core_cmd_bus
  import bus_pkg::*;
#(
  parameter int  NUM_CORES     = 4,
  parameter int  ACK_TIMEOUT   = 64,
  localparam int CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [NUM_CORES-1:0]               send_req,
  input  logic [NUM_CORES-1:0]               broadcast_mode,
  input  logic [NUM_CORES*CORE_ID_WIDTH-1:0] dst_ids,
  input  logic [NUM_CORES*2-1:0]             instructions,
  output logic [NUM_CORES-1:0]               send_grant,
  output logic [NUM_CORES-1:0]               cmd_valid,
  output logic [1:0]                         cmd_instr,
  output logic [CORE_ID_WIDTH-1:0]           cmd_src,
  input  logic [NUM_CORES-1:0]               cmd_ack,
  output logic                               bus_busy,
  output logic                               bus_error,
  output logic [CORE_ID_WIDTH-1:0]           err_src
);

  localparam int W  = CORE_ID_WIDTH;
  localparam int CW = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT - 1);

  cmd_state_t state_q, state_d;

  // pending slots
  logic [NUM_CORES-1:0]                  pend_q, pend_d;
  logic [NUM_CORES-1:0]                  slot_bcast_q, slot_bcast_d;
  logic [NUM_CORES-1:0][W-1:0]           slot_dst_q, slot_dst_d;
  bus_instruction_t [NUM_CORES-1:0]      slot_instr_q, slot_instr_d;

  // active transaction
  logic [NUM_CORES-1:0] txn_mask_q, txn_mask_d;
  bus_instruction_t     txn_instr_q, txn_instr_d;
  logic [W-1:0]         txn_src_q, txn_src_d;
  logic [W-1:0]         ptr_q, ptr_d;
  logic [NUM_CORES-1:0] ack_seen_q, ack_seen_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [NUM_CORES-1:0] cmd_valid_q, cmd_valid_d;
  logic                 bus_err_q, bus_err_d;
  logic [W-1:0]         err_src_q, err_src_d;

  logic [NUM_CORES-1:0] arb_gnt;
  logic [W-1:0]         arb_idx;
  logic                 arb_any;
  logic [NUM_CORES-1:0] sel_mask;
  logic [NUM_CORES-1:0] ack_now;

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .req_i     (pend_q),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  // An out-of-range unicast id matches no core and yields an empty mask.
  always_comb begin
    sel_mask = '0;
    for (int j = 0; j < NUM_CORES; j++)
      sel_mask[j] = slot_bcast_q[arb_idx] | (int'(slot_dst_q[arb_idx]) == j);
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    slot_bcast_d = slot_bcast_q;
    slot_dst_d   = slot_dst_q;
    slot_instr_d = slot_instr_q;
    txn_mask_d   = txn_mask_q;
    txn_instr_d  = txn_instr_q;
    txn_src_d    = txn_src_q;
    ptr_d        = ptr_q;
    ack_seen_d   = ack_seen_q;
    cnt_d        = cnt_q;
    grant_d      = '0;
    cmd_valid_d  = cmd_valid_q;
    bus_err_d    = 1'b0;
    err_src_d    = err_src_q;
    ack_now      = '0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          ptr_d           = arb_idx;
          pend_d[arb_idx] = 1'b0;
          txn_mask_d      = sel_mask;
          txn_instr_d     = slot_instr_q[arb_idx];
          txn_src_d       = arb_idx;
          grant_d         = arb_gnt;
          ack_seen_d      = '0;
          cnt_d           = '0;
          if (sel_mask == '0) begin
            bus_err_d = 1'b1;
            err_src_d = arb_idx;
          end else begin
            state_d     = SEND;
            cmd_valid_d = sel_mask;
          end
        end
      end
      SEND: begin
        ack_now    = ack_seen_q | (cmd_ack & txn_mask_q);
        ack_seen_d = ack_now;
        cnt_d      = cnt_q + 1'b1;
        // completion is tested first so it wins over a same-cycle timeout
        if (ack_now == txn_mask_q) begin
          state_d     = IDLE;
          cmd_valid_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = IDLE;
          cmd_valid_d = '0;
          bus_err_d   = 1'b1;
          err_src_d   = txn_src_q;
        end else begin
          cmd_valid_d = txn_mask_q & ~ack_now;
        end
      end
      default: state_d = IDLE;
    endcase

    // a fresh request overrides the clear of a slot being granted this cycle
    for (int i = 0; i < NUM_CORES; i++) begin
      if (send_req[i]) begin
        pend_d[i]       = 1'b1;
        slot_bcast_d[i] = broadcast_mode[i];
        slot_dst_d[i]   = dst_ids[i*W +: W];
        slot_instr_d[i] = bus_instruction_t'(instructions[i*2 +: 2]);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      slot_bcast_q <= '0;
      slot_dst_q   <= '0;
      slot_instr_q <= '0;
      txn_mask_q   <= '0;
      txn_instr_q  <= HALT_PAUSE;
      txn_src_q    <= '0;
      ptr_q        <= W'(NUM_CORES - 1);
      ack_seen_q   <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      cmd_valid_q  <= '0;
      bus_err_q    <= 1'b0;
      err_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      slot_bcast_q <= slot_bcast_d;
      slot_dst_q   <= slot_dst_d;
      slot_instr_q <= slot_instr_d;
      txn_mask_q   <= txn_mask_d;
      txn_instr_q  <= txn_instr_d;
      txn_src_q    <= txn_src_d;
      ptr_q        <= ptr_d;
      ack_seen_q   <= ack_seen_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      cmd_valid_q  <= cmd_valid_d;
      bus_err_q    <= bus_err_d;
      err_src_q    <= err_src_d;
    end
  end

  assign send_grant = grant_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_instr  = txn_instr_q;
  assign cmd_src    = txn_src_q;
  assign bus_busy   = (state_q == SEND);
  assign bus_error  = bus_err_q;
  assign err_src    = err_src_q;

endmodule

// File: tb/tb_core_cmd_bus.sv
// Directed bench for core_cmd_bus: expected grants/errors go to a scoreboard
// checked by a negedge monitor; cycle-exact waveform points are checked inline.
module tb_core_cmd_bus;

  logic       clk;
  logic       resetn;
  logic [3:0] send_req, broadcast_mode, cmd_ack;
  logic [7:0] dst_ids, instructions;
  logic [3:0] send_grant, cmd_valid;
  logic [1:0] cmd_instr, cmd_src, err_src;
  logic       bus_busy, bus_error;

  typedef struct {
    int         src;
    logic [1:0] instr;
    logic [3:0] mask;
  } exp_t;

  exp_t sb_q[$];
  int   err_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  core_cmd_bus #(.NUM_CORES(4), .ACK_TIMEOUT(64)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .send_req       (send_req),
    .broadcast_mode (broadcast_mode),
    .dst_ids        (dst_ids),
    .instructions   (instructions),
    .send_grant     (send_grant),
    .cmd_valid      (cmd_valid),
    .cmd_instr      (cmd_instr),
    .cmd_src        (cmd_src),
    .cmd_ack        (cmd_ack),
    .bus_busy       (bus_busy),
    .bus_error      (bus_error),
    .err_src        (err_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic b, input logic [1:0] d, input logic [1:0] ins);
    broadcast_mode[s]     = b;
    dst_ids[s*2 +: 2]      = d;
    instructions[s*2 +: 2] = ins;
  endtask

  task automatic push_exp(input int s, input logic [1:0] ins, input logic [3:0] m);
    exp_t e;
    e.src = s; e.instr = ins; e.mask = m;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
  endtask

  // monitor: every grant / error the DUT presents is matched against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && send_grant != 4'b0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_grant", {28'b0, send_grant}, 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_grant", {20'b0, send_grant, 2'b0, cmd_instr, 2'b0, cmd_src, cmd_valid},
              {20'b0, 4'(1 << e.src), 2'b0, e.instr, 2'b0, 2'(e.src), e.mask});
        end
      end
      if (resetn && bus_error) begin
        if (err_q.size() == 0) chk("unexpected_error", {30'b0, err_src}, 32'hFFFF_FFFF);
        else chk("sb_err_src", {30'b0, err_src}, 32'(err_q.pop_front()));
      end
    end
  end

  initial begin
    resetn = 1'b1; send_req = '0; broadcast_mode = '0; cmd_ack = '0;
    dst_ids = '0; instructions = '0;
    #2 resetn = 1'b0;
    tick(); tick();
    chk("reset_outputs", {16'b0, send_grant, cmd_valid, cmd_instr, cmd_src, bus_busy, bus_error, err_src}, 32'h0);
    resetn = 1'b1;
    tick();

    // 1: unicast src1 -> dst2 STOP
    set_src(1, 1'b0, 2'd2, 2'b01); push_exp(1, 2'b01, 4'b0100);
    send_req = 4'b0010; tick(); send_req = '0;
    chk("t1_no_grant_T1", {28'b0, send_grant}, 32'h0);
    tick();
    chk("t1_grant_T2", {28'b0, send_grant}, 32'h2);
    chk("t1_busy", {31'b0, bus_busy}, 32'h1);
    tick(); tick();
    chk("t1_hold_T4", {28'b0, cmd_valid}, 32'h4);
    tick(); cmd_ack = 4'b0100;
    tick(); cmd_ack = '0;
    chk("t1_valid_T6", {28'b0, cmd_valid}, 32'h0);
    chk("t1_idle_T6", {30'b0, bus_busy, bus_error}, 32'h0);

    // 2: broadcast src0 CONTINUE, staggered acks
    tick();
    set_src(0, 1'b1, 2'd0, 2'b10); push_exp(0, 2'b10, 4'b1111);
    send_req = 4'b0001; tick(); send_req = '0;
    tick();
    chk("t2_valid_T2", {28'b0, cmd_valid}, 32'hF);
    tick(); cmd_ack = 4'b1001;
    tick(); cmd_ack = 4'b0010;
    chk("t2_valid_T4", {28'b0, cmd_valid}, 32'h6);
    tick(); cmd_ack = '0;
    chk("t2_valid_T5", {28'b0, cmd_valid}, 32'h4);
    tick(); cmd_ack = 4'b0100;
    chk("t2_valid_T6", {28'b0, cmd_valid}, 32'h4);
    tick(); cmd_ack = '0;
    chk("t2_valid_T7", {28'b0, cmd_valid}, 32'h0);
    tick();

    // 3: round-robin contention from a fresh pointer, src0 re-requests while src2 is active
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_src(i, 1'b0, 2'((i + 1) % 4), 2'(i));
      push_exp(i, 2'(i), 4'(1 << ((i + 1) % 4)));
    end
    send_req = 4'b1111; tick(); send_req = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t3_rr_order", {28'b0, send_grant}, 32'(1 << k));
      if (k == 2) begin
        set_src(0, 1'b0, 2'd3, 2'b11); push_exp(0, 2'b11, 4'b1000);
        send_req = 4'b0001;
      end
      tick(); send_req = '0; cmd_ack = cmd_valid;
      tick(); cmd_ack = '0;
      chk("t3_released", {28'b0, cmd_valid}, 32'h0);
      tick();
    end
    chk("t3_src0_after_3", {28'b0, send_grant}, 32'h1);
    tick(); cmd_ack = 4'b1000;
    tick(); cmd_ack = '0;
    tick();

    // 5: overwrite while waiting, then same-cycle re-request at selection
    set_src(1, 1'b0, 2'd0, 2'b01); push_exp(1, 2'b01, 4'b0001);
    send_req = 4'b0010; tick(); send_req = '0;
    tick();
    tick(); set_src(2, 1'b0, 2'd3, 2'b00); send_req = 4'b0100;
    tick(); set_src(2, 1'b0, 2'd3, 2'b11); send_req = 4'b0100;
    tick(); send_req = '0;
    chk("t5_src1_held", {28'b0, cmd_valid}, 32'h1);
    tick(); cmd_ack = 4'b0001;
    tick(); cmd_ack = '0;
    set_src(2, 1'b0, 2'd0, 2'b10); send_req = 4'b0100;
    push_exp(2, 2'b11, 4'b1000); push_exp(2, 2'b10, 4'b0001);
    tick(); send_req = '0;
    chk("t5_latest_wins", {28'b0, send_grant, 2'b0, cmd_instr}, {28'b0, 4'b0100, 2'b0, 2'b11});
    cmd_ack = 4'b1000;
    tick(); cmd_ack = '0;
    tick();
    chk("t5_second_cmd", {28'b0, send_grant, 2'b0, cmd_instr}, {28'b0, 4'b0100, 2'b0, 2'b10});
    cmd_ack = 4'b0001;
    tick(); cmd_ack = '0;
    tick();

    // 4: timeout on src3 -> dst1, src0 pending behind it
    set_src(3, 1'b0, 2'd1, 2'b00); set_src(0, 1'b0, 2'd2, 2'b01);
    push_exp(3, 2'b00, 4'b0010); err_q.push_back(3); push_exp(0, 2'b01, 4'b0100);
    send_req = 4'b1001; tick(); send_req = '0;
    tick();
    chk("t4_grant3", {28'b0, send_grant}, 32'h8);
    for (int i = 1; i <= 63; i++) tick();
    chk("t4_pre_timeout", {27'b0, bus_error, cmd_valid}, 32'h2);
    tick();
    chk("t4_timeout", {26'b0, bus_error, err_src, cmd_valid, bus_busy}, {26'b0, 1'b1, 2'd3, 4'b0, 1'b0});
    tick();
    chk("t4_next_served", {27'b0, bus_error, send_grant}, 32'h1);
    cmd_ack = 4'b0100;
    tick(); cmd_ack = '0;
    tick();

    // 6: reset while a command is held and two slots are pending
    set_src(1, 1'b0, 2'd2, 2'b01); push_exp(1, 2'b01, 4'b0100);
    send_req = 4'b0010; tick(); send_req = '0;
    tick();
    set_src(0, 1'b1, 2'd0, 2'b11); set_src(3, 1'b0, 2'd0, 2'b10);
    send_req = 4'b1001; tick(); send_req = '0;
    tick();
    chk("t6_held_pre_reset", {28'b0, cmd_valid}, 32'h4);
    resetn = 1'b0;
    #1;
    chk("t6_async_reset", {16'b0, send_grant, cmd_valid, cmd_instr, cmd_src, bus_busy, bus_error, err_src}, 32'h0);
    tick(); tick();
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_no_grant", {24'b0, send_grant, cmd_valid}, 32'h0);
    end
    set_src(2, 1'b0, 2'd1, 2'b10); push_exp(2, 2'b10, 4'b0010);
    send_req = 4'b0100; tick(); send_req = '0;
    tick();
    chk("t6_fresh_grant", {28'b0, send_grant}, 32'h4);
    cmd_ack = 4'b0010;
    tick(); cmd_ack = '0;
    tick(); tick();

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    chk("err_drained", 32'(err_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
